prv_trap_sequencer: RTL and testbench

PRV_TRAP_SEQUENCER -- requirements
Module: prv_trap_sequencer

---
 rtl/prv_trap_sequencer_if.sv | 27 ++
 rtl/prv_trap_sequencer.sv | 89 ++++++++
 tb/tb_prv_trap_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/prv_trap_sequencer_if.sv
// prv_trap_sequencer_if: pipeline-side event inputs and CSR/fetch-side results of the trap sequencer
interface prv_trap_sequencer_if;
  typedef logic [31:0] word_t;
  logic  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env;
  logic  prot_fault_i, prot_fault_l, prot_fault_s;
  logic  ret;
  logic  ext_int, soft_int, timer_int;
  logic  mstatus_mie, meie, msie, mtie;
  logic  pipe_clear;
  word_t epc, badaddr, mtvec, mepc_r;
  logic  insert_pc;
  word_t priv_pc;
  logic  intr, trap_valid, ret_commit, busy;
  word_t mcause, mepc_wdata, mtval_wdata;
  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env,
    output prot_fault_i, prot_fault_l, prot_fault_s, ret, ext_int, soft_int, timer_int,
    output mstatus_mie, meie, msie, mtie, pipe_clear, epc, badaddr, mtvec, mepc_r,
    input  insert_pc, priv_pc, intr, trap_valid, mcause, mepc_wdata, mtval_wdata, ret_commit, busy
  );
  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env,
    input  prot_fault_i, prot_fault_l, prot_fault_s, ret, ext_int, soft_int, timer_int,
    input  mstatus_mie, meie, msie, mtie, pipe_clear, epc, badaddr, mtvec, mepc_r,
    output insert_pc, priv_pc, intr, trap_valid, mcause, mepc_wdata, mtval_wdata, ret_commit, busy
  );
endinterface

// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer: latches the winning exception/interrupt/mret, drains the pipe, then redirects fetch
module prv_trap_sequencer (
  input logic                 CLK,
  input logic                 nRST,
  prv_trap_sequencer_if.slave trap_io
);
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;
  typedef enum logic [1:0] {K_EXC, K_INT, K_RET} kind_t;
  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  word_t      pc_q, pc_d, cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
  logic       f_insn, f_l, f_s, exc, irq_ext, irq_soft, irq_tim, irq;
  logic [4:0] exc_code, int_code;
  word_t      base;
  always_comb begin
    f_insn   = trap_io.fault_insn | trap_io.prot_fault_i;
    f_l      = trap_io.fault_l | trap_io.prot_fault_l;
    f_s      = trap_io.fault_s | trap_io.prot_fault_s;
    exc      = |{trap_io.breakpoint, f_insn, trap_io.mal_insn, trap_io.illegal_insn, trap_io.env,
                 trap_io.mal_s, trap_io.mal_l, f_s, f_l};
    irq_ext  = trap_io.ext_int & trap_io.meie;
    irq_soft = trap_io.soft_int & trap_io.msie;
    irq_tim  = trap_io.timer_int & trap_io.mtie;
    irq      = trap_io.mstatus_mie & (irq_ext | irq_soft | irq_tim);
    exc_code = trap_io.breakpoint   ? 5'd3  :
               f_insn               ? 5'd1  :
               trap_io.mal_insn     ? 5'd0  :
               trap_io.illegal_insn ? 5'd2  :
               trap_io.env          ? 5'd11 :
               trap_io.mal_s        ? 5'd6  :
               trap_io.mal_l        ? 5'd4  :
               f_s                  ? 5'd7  : 5'd5;
    int_code = irq_ext ? 5'd11 : irq_soft ? 5'd3 : 5'd7;
    base     = {trap_io.mtvec[31:2], 2'b00};
  end
  // Only the IDLE branch samples the event inputs, so everything latched stays frozen until the next IDLE.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    unique case (state_q)
      IDLE: if (exc | irq | trap_io.ret) begin
        state_d = DRAIN;
        kind_d  = exc ? K_EXC : irq ? K_INT : K_RET;
        pc_d    = exc ? base :
                  irq ? (trap_io.mtvec[1:0] == 2'b01 ? base + {25'd0, int_code, 2'b00} : base) :
                  trap_io.mepc_r;
        if (exc | irq) begin
          cause_d = exc ? {27'd0, exc_code} : {1'b1, 26'd0, int_code};
          epc_d   = trap_io.epc;
          tval_d  = (exc && exc_code inside {5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7}) ? trap_io.badaddr : '0;
        end
      end
      DRAIN:    state_d = trap_io.pipe_clear ? REDIRECT : DRAIN;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      kind_q  <= K_EXC;
      pc_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end
  assign trap_io.busy        = state_q != IDLE;
  assign trap_io.insert_pc   = state_q == REDIRECT;
  assign trap_io.trap_valid  = state_q == REDIRECT && kind_q != K_RET;
  assign trap_io.ret_commit  = state_q == REDIRECT && kind_q == K_RET;
  assign trap_io.intr        = state_q != IDLE && kind_q == K_INT;
  assign trap_io.priv_pc     = pc_q;
  assign trap_io.mcause      = cause_q;
  assign trap_io.mepc_wdata  = epc_q;
  assign trap_io.mtval_wdata = tval_q;
endmodule

// File: tb/tb_prv_trap_sequencer.sv
// tb_prv_trap_sequencer: directed spot checks plus randomized traffic against a transaction-level model
module tb_prv_trap_sequencer;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  prv_trap_sequencer_if tif();
  prv_trap_sequencer dut (.CLK(CLK), .nRST(nRST), .trap_io(tif));
  int checks = 0;
  int failures = 0;
  bit mdl_on = 1'b0;
  typedef struct {
    int          kind;
    logic [31:0] pc, cause, epc, tval;
  } txn_t;
  int   phase = 0;
  txn_t cur;
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // Decide which event wins from the priority tables; returns 0 when nothing is pending.
  function automatic bit pick(output txn_t t);
    logic        ex[9];
    logic        ie[3];
    logic [31:0] ecode[9];
    logic [31:0] icode[3];
    logic [31:0] base;
    ecode = '{32'd3, 32'd1, 32'd0, 32'd2, 32'd11, 32'd6, 32'd4, 32'd7, 32'd5};
    icode = '{32'd11, 32'd3, 32'd7};
    ex = '{tif.breakpoint, tif.fault_insn | tif.prot_fault_i, tif.mal_insn, tif.illegal_insn, tif.env,
           tif.mal_s, tif.mal_l, tif.fault_s | tif.prot_fault_s, tif.fault_l | tif.prot_fault_l};
    ie = '{tif.ext_int & tif.meie, tif.soft_int & tif.msie, tif.timer_int & tif.mtie};
    base = tif.mtvec & ~32'h3;
    t.kind = 0; t.pc = '0; t.cause = '0; t.epc = tif.epc; t.tval = '0;
    for (int i = 0; i < 9; i++)
      if (ex[i]) begin
        t.cause = ecode[i];
        t.pc = base;
        t.tval = (ecode[i] inside {0, 1, 4, 5, 6, 7}) ? tif.badaddr : '0;
        return 1'b1;
      end
    if (tif.mstatus_mie)
      for (int i = 0; i < 3; i++)
        if (ie[i]) begin
          t.kind = 1;
          t.cause = 32'h8000_0000 | icode[i];
          t.pc = (tif.mtvec % 4 == 1) ? base + (icode[i] << 2) : base;
          return 1'b1;
        end
    if (tif.ret) begin
      t.kind = 2;
      t.pc = tif.mepc_r;
      return 1'b1;
    end
    return 1'b0;
  endfunction
  always @(posedge CLK) begin
    txn_t t;
    if (!nRST) phase = 0;
    else if (phase == 0) begin
      if (pick(t)) begin
        cur = t;
        phase = 1;
      end
    end else if (phase == 1) phase = tif.pipe_clear ? 2 : 1;
    else phase = 0;
    #1;
    if (mdl_on) begin
      chk1("m_busy", tif.busy, phase != 0);
      chk1("m_insert_pc", tif.insert_pc, phase == 2);
      chk1("m_trap_valid", tif.trap_valid, phase == 2 && cur.kind != 2);
      chk1("m_ret_commit", tif.ret_commit, phase == 2 && cur.kind == 2);
      chk1("m_intr", tif.intr, phase != 0 && cur.kind == 1);
      if (phase == 2) chk32("m_priv_pc", tif.priv_pc, cur.pc);
      if (phase == 2 && cur.kind != 2) begin
        chk32("m_mcause", tif.mcause, cur.cause);
        chk32("m_mepc", tif.mepc_wdata, cur.epc);
        chk32("m_mtval", tif.mtval_wdata, cur.tval);
      end
    end
  end
  task automatic clear_in();
    {tif.fault_insn, tif.mal_insn, tif.illegal_insn, tif.fault_l, tif.mal_l, tif.fault_s, tif.mal_s,
     tif.breakpoint, tif.env} = '0;
    {tif.prot_fault_i, tif.prot_fault_l, tif.prot_fault_s, tif.ret} = '0;
    {tif.ext_int, tif.soft_int, tif.timer_int, tif.mstatus_mie, tif.meie, tif.msie, tif.mtie} = '0;
    tif.pipe_clear = 1'b1;
    tif.epc = '0; tif.badaddr = '0; tif.mtvec = '0; tif.mepc_r = '0;
  endtask
  function automatic logic rare();
    return $urandom_range(0, 39) == 0;
  endfunction
  task automatic rand_in();
    tif.fault_insn = rare(); tif.mal_insn = rare(); tif.illegal_insn = rare();
    tif.fault_l = rare(); tif.mal_l = rare(); tif.fault_s = rare(); tif.mal_s = rare();
    tif.breakpoint = rare(); tif.env = rare();
    tif.prot_fault_i = rare(); tif.prot_fault_l = rare(); tif.prot_fault_s = rare();
    tif.ret = $urandom_range(0, 5) == 0;
    tif.ext_int = $urandom_range(0, 3) == 0;
    tif.soft_int = $urandom_range(0, 3) == 0;
    tif.timer_int = $urandom_range(0, 3) == 0;
    tif.mstatus_mie = $urandom_range(0, 3) != 0;
    tif.meie = 1'($urandom_range(0, 1)); tif.msie = 1'($urandom_range(0, 1)); tif.mtie = 1'($urandom_range(0, 1));
    tif.pipe_clear = $urandom_range(0, 2) != 0;
    tif.epc = $urandom(); tif.badaddr = $urandom(); tif.mtvec = $urandom(); tif.mepc_r = $urandom();
  endtask
  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, tif.busy, 1'b0);
    chk1({tag, "_insert_pc"}, tif.insert_pc, 1'b0);
    chk1({tag, "_intr"}, tif.intr, 1'b0);
    chk1({tag, "_trap_valid"}, tif.trap_valid, 1'b0);
    chk1({tag, "_ret_commit"}, tif.ret_commit, 1'b0);
    chk32({tag, "_priv_pc"}, tif.priv_pc, 32'h0);
    chk32({tag, "_mcause"}, tif.mcause, 32'h0);
    chk32({tag, "_mepc"}, tif.mepc_wdata, 32'h0);
    chk32({tag, "_mtval"}, tif.mtval_wdata, 32'h0);
  endtask
  int busy_n, rc_n, tv_n, ins_n;
  initial begin
    clear_in();
    repeat (2) @(posedge CLK);
    #1 chk_all_zero("rst");
    @(negedge CLK) nRST = 1'b1;
    mdl_on = 1'b1;
    // illegal instruction, direct vector, mtval forced to zero
    @(negedge CLK);
    tif.illegal_insn = 1'b1; tif.epc = 32'h200; tif.mtvec = 32'h1000; tif.badaddr = 32'hdead;
    @(posedge CLK) #1 chk1("ill_busy", tif.busy, 1'b1);
    chk1("ill_no_early", tif.insert_pc, 1'b0);
    @(negedge CLK) clear_in();
    @(posedge CLK) #1 chk1("ill_insert", tif.insert_pc, 1'b1);
    chk32("ill_pc", tif.priv_pc, 32'h1000);
    chk1("ill_tv", tif.trap_valid, 1'b1);
    chk32("ill_cause", tif.mcause, 32'd2);
    chk32("ill_mepc", tif.mepc_wdata, 32'h200);
    chk32("ill_mtval", tif.mtval_wdata, 32'h0);
    @(posedge CLK) #1 chk1("ill_idle", tif.busy, 1'b0);
    // vectored timer interrupt
    @(negedge CLK);
    tif.timer_int = 1'b1; tif.mtie = 1'b1; tif.mstatus_mie = 1'b1; tif.mtvec = 32'h1001;
    @(posedge CLK) #1 chk1("tim_intr_drain", tif.intr, 1'b1);
    @(negedge CLK) clear_in();
    @(posedge CLK) #1 chk1("tim_insert", tif.insert_pc, 1'b1);
    chk32("tim_pc", tif.priv_pc, 32'h101C);
    chk32("tim_cause", tif.mcause, 32'h8000_0007);
    chk1("tim_intr_redir", tif.intr, 1'b1);
    @(posedge CLK) #1 chk1("tim_intr_idle", tif.intr, 1'b0);
    // exception beats a simultaneous eligible interrupt
    @(negedge CLK);
    tif.mal_l = 1'b1; tif.ext_int = 1'b1; tif.meie = 1'b1; tif.mstatus_mie = 1'b1;
    tif.badaddr = 32'h33; tif.mtvec = 32'h2001;
    @(posedge CLK) #1 chk1("mal_intr_drain", tif.intr, 1'b0);
    @(negedge CLK) clear_in();
    @(posedge CLK) #1 chk32("mal_cause", tif.mcause, 32'd4);
    chk32("mal_mtval", tif.mtval_wdata, 32'h33);
    chk32("mal_pc", tif.priv_pc, 32'h2000);
    chk1("mal_intr", tif.intr, 1'b0);
    @(posedge CLK);
    // mret with a 5-cycle pipeline drain
    @(negedge CLK);
    tif.ret = 1'b1; tif.mepc_r = 32'h400; tif.pipe_clear = 1'b0;
    busy_n = 0; rc_n = 0; tv_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK) #1;
      busy_n += int'(tif.busy); rc_n += int'(tif.ret_commit); tv_n += int'(tif.trap_valid);
      if (tif.ret_commit) chk32("ret_pc", tif.priv_pc, 32'h400);
      @(negedge CLK);
      tif.ret = 1'b0;
      tif.pipe_clear = k >= 5;
    end
    chk32("ret_busy_cycles", 32'(busy_n), 32'd7);
    chk32("ret_commit_count", 32'(rc_n), 32'd1);
    chk32("ret_trap_valid_count", 32'(tv_n), 32'd0);
    // asynchronous reset mid-drain aborts the sequence
    clear_in();
    tif.illegal_insn = 1'b1; tif.mtvec = 32'h3000; tif.pipe_clear = 1'b0;
    @(posedge CLK) #1 chk1("abort_busy", tif.busy, 1'b1);
    @(negedge CLK) tif.illegal_insn = 1'b0;
    #2 nRST = 1'b0;
    #1 chk_all_zero("abort");
    @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    tif.pipe_clear = 1'b1;
    ins_n = 0;
    repeat (4) begin
      @(posedge CLK) #1;
      ins_n += int'(tif.insert_pc | tif.trap_valid | tif.busy);
    end
    chk32("abort_no_strobe", 32'(ins_n), 32'd0);
    // interrupt masked globally
    @(negedge CLK);
    tif.timer_int = 1'b1; tif.mtie = 1'b1; tif.mstatus_mie = 1'b0;
    repeat (3) begin
      @(posedge CLK) #1 chk1("masked_busy", tif.busy, 1'b0);
    end
    @(negedge CLK) clear_in();
    repeat (3000) begin
      @(negedge CLK) rand_in();
    end
    @(negedge CLK) clear_in();
    repeat (4) @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
